// File: rtl/branch_update_ctrl_pkg.sv
// Shared branch-predictor definitions: default geometry and the update-controller state encoding.
package branch_update_ctrl_pkg;

    localparam int QDEPTH_DEF = 4;
    localparam int HIST_DEF   = 8;
    localparam int IDX_DEF    = 12;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_queue.sv
// In-flight branch FIFO: push at tail, pop at head, single-cycle clear; pointers wrap modulo DEPTH.
module branch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH[PW:0]);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Clear dominates any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Tracks predicted branches between fetch and execute, maintains speculative/committed history,
// emits predictor-table updates and a one-cycle flush on misprediction.
module branch_update_ctrl
    import branch_update_ctrl_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int HIST   = HIST_DEF,
    parameter int IDX    = IDX_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alloc_valid,
    input  logic [31:0]                    alloc_pc,
    input  logic                           alloc_pred,
    output logic                           alloc_ready,
    input  logic                           res_valid,
    input  logic                           res_taken,
    output logic [HIST-1:0]                spec_hist,
    output logic                           upd_valid,
    output logic [IDX-1:0]                 upd_index,
    output logic                           upd_taken,
    output logic                           flush,
    output logic [31:0]                    branch_cnt,
    output logic [31:0]                    correct_cnt,
    output logic                           err_underflow,
    output logic                           dbg_state,
    output logic [count_width(QDEPTH)-1:0] dbg_count
);

    localparam int EW = 32 + 1 + HIST;

    ctrl_state_t   state_q;
    ctrl_state_t   state_d;
    logic [HIST-1:0] commit_hist;
    logic [HIST-1:0] commit_next;

    logic          q_full;
    logic          q_empty;
    logic [EW-1:0] q_wdata;
    logic [EW-1:0] q_rdata;

    logic            accept;
    logic            pop;
    logic            mispredict;
    logic [31:0]     head_pc;
    logic            head_pred;
    logic [HIST-1:0] head_snap;
    logic [IDX-1:0]  pop_index;

    // Entry layout: {pc, prediction, history snapshot at allocation}.
    assign q_wdata   = {alloc_pc, alloc_pred, spec_hist};
    assign head_pc   = q_rdata[EW-1 -: 32];
    assign head_pred = q_rdata[HIST];
    assign head_snap = q_rdata[HIST-1:0];

    assign alloc_ready = (state_q == ST_RUN) && !q_full;
    assign accept      = alloc_valid && alloc_ready;
    assign pop         = res_valid && !q_empty;
    assign mispredict  = pop && (res_taken != head_pred);
    assign commit_next = {commit_hist[HIST-2:0], res_taken};

    // High index bits fold the allocation-time history into the PC; low bits are plain PC.
    assign pop_index = {head_snap ^ head_pc[IDX+1:IDX-HIST+2], head_pc[IDX-HIST+1:2]};

    assign dbg_state = state_q;

    branch_queue #(
        .DEPTH (QDEPTH),
        .W     (EW)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && !mispredict),
        .pop   (pop),
        .clear (mispredict),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (dbg_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_hist     <= '0;
            commit_hist   <= '0;
            upd_valid     <= 1'b0;
            upd_index     <= '0;
            upd_taken     <= 1'b0;
            flush         <= 1'b0;
            branch_cnt    <= '0;
            correct_cnt   <= '0;
            err_underflow <= 1'b0;
        end else begin
            upd_valid <= pop;
            flush     <= mispredict;
            if (pop) begin
                upd_index   <= pop_index;
                upd_taken   <= res_taken;
                commit_hist <= commit_next;
                branch_cnt  <= branch_cnt + 32'd1;
                if (!mispredict) begin
                    correct_cnt <= correct_cnt + 32'd1;
                end
            end
            // A mispredict discards any same-cycle allocation and its history shift.
            if (mispredict) begin
                spec_hist <= commit_next;
            end else if (accept) begin
                spec_hist <= {spec_hist[HIST-2:0], alloc_pred};
            end
            if (res_valid && q_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl: cycle-by-cycle vector table plus a correct-prediction stream.
module tb_branch_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_ready;
    logic        res_valid;
    logic        res_taken;
    logic [7:0]  spec_hist;
    logic        upd_valid;
    logic [11:0] upd_index;
    logic        upd_taken;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] correct_cnt;
    logic        err_underflow;
    logic        dbg_state;
    logic [2:0]  dbg_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_update_ctrl #(
        .QDEPTH (4),
        .HIST   (8),
        .IDX    (12)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid   (alloc_valid),
        .alloc_pc      (alloc_pc),
        .alloc_pred    (alloc_pred),
        .alloc_ready   (alloc_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .spec_hist     (spec_hist),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .correct_cnt   (correct_cnt),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [31:0] pc;
        logic        ap;
        logic        rv;
        logic        rt;
        logic        e_rdy;
        logic [7:0]  e_sh;
        logic        e_uv;
        logic [11:0] e_ui;
        logic        e_ut;
        logic        e_fl;
        logic [31:0] e_bc;
        logic [31:0] e_cc;
        logic        e_uf;
        logic [2:0]  e_cnt;
        logic        e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic av, input logic [31:0] pc, input logic ap,
                       input logic rv, input logic rt, input logic rdy, input logic [7:0] sh,
                       input logic uv, input logic [11:0] ui, input logic ut, input logic fl,
                       input logic [31:0] bc, input logic [31:0] cc, input logic uf,
                       input logic [2:0] cnt, input logic st);
        vec_t v;
        v.rst_n = r;   v.av = av;     v.pc = pc;     v.ap = ap;   v.rv = rv;   v.rt = rt;
        v.e_rdy = rdy; v.e_sh = sh;   v.e_uv = uv;   v.e_ui = ui; v.e_ut = ut; v.e_fl = fl;
        v.e_bc = bc;   v.e_cc = cc;   v.e_uf = uf;   v.e_cnt = cnt; v.e_st = st;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the edge for sampling.
    task automatic drive(input logic r, input logic av, input logic [31:0] pc, input logic ap,
                         input logic rv, input logic rt);
        rst_n       = r;
        alloc_valid = av;
        alloc_pc    = pc;
        alloc_pred  = ap;
        res_valid   = rv;
        res_taken   = rt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_index(input logic [31:0] pc, input logic [7:0] snap);
        logic [7:0] hi;
        logic [3:0] lo;
        hi = pc[13:6] ^ snap;
        lo = pc[5:2];
        return {hi, lo};
    endfunction

    initial begin
        logic [7:0]  sh_m;
        logic [7:0]  snap;
        logic [31:0] bc_m;
        logic [31:0] pc;
        logic        pred;

        rst_n = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0;

        //  rst av pc            ap rv rt | rdy sh     uv ui      ut fl bc cc uf cnt st
        add(0, 0, 32'h0,        0, 0, 0,  1, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 32'h00010040, 1, 0, 0,  1, 8'h01, 0, 12'h000, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 32'h0,        0, 1, 1,  1, 8'h01, 1, 12'h010, 1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 32'h0,        0, 0, 0,  1, 8'h01, 0, 12'h000, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 32'h0,        0, 1, 0,  1, 8'h01, 0, 12'h000, 0, 0, 1, 1, 1, 0, 0);
        add(1, 0, 32'h0,        0, 0, 0,  1, 8'h01, 0, 12'h000, 0, 0, 1, 1, 1, 0, 0);
        add(1, 1, 32'h100,      1, 0, 0,  1, 8'h03, 0, 12'h000, 0, 0, 1, 1, 1, 1, 0);
        add(1, 1, 32'h204,      0, 0, 0,  1, 8'h06, 0, 12'h000, 0, 0, 1, 1, 1, 2, 0);
        add(1, 1, 32'h1008,     1, 0, 0,  1, 8'h0D, 0, 12'h000, 0, 0, 1, 1, 1, 3, 0);
        add(1, 1, 32'h0C,       1, 0, 0,  0, 8'h1B, 0, 12'h000, 0, 0, 1, 1, 1, 4, 0);
        add(1, 1, 32'h40,       0, 0, 0,  0, 8'h1B, 0, 12'h000, 0, 0, 1, 1, 1, 4, 0);
        add(1, 1, 32'h40,       0, 1, 1,  1, 8'h1B, 1, 12'h050, 1, 0, 2, 2, 1, 3, 0);
        add(1, 1, 32'h80,       1, 1, 0,  1, 8'h37, 1, 12'h0B1, 0, 0, 3, 3, 1, 3, 0);
        add(1, 1, 32'h0,        1, 1, 0,  0, 8'h0C, 1, 12'h462, 0, 1, 4, 3, 1, 0, 1);
        add(1, 1, 32'h300,      1, 0, 0,  1, 8'h0C, 0, 12'h000, 0, 0, 4, 3, 1, 0, 0);
        add(0, 0, 32'h0,        0, 0, 0,  1, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 32'h10,       1, 0, 0,  1, 8'h01, 0, 12'h000, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 32'h20,       1, 0, 0,  1, 8'h03, 0, 12'h000, 0, 0, 0, 0, 0, 2, 0);
        add(1, 1, 32'h30,       0, 0, 0,  1, 8'h06, 0, 12'h000, 0, 0, 0, 0, 0, 3, 0);
        add(1, 0, 32'h0,        0, 1, 0,  0, 8'h00, 1, 12'h004, 0, 1, 1, 0, 0, 0, 1);
        add(1, 0, 32'h0,        0, 0, 0,  1, 8'h00, 0, 12'h000, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 32'h44,       1, 0, 0,  1, 8'h01, 0, 12'h000, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 32'h0,        0, 1, 0,  0, 8'h00, 1, 12'h011, 0, 1, 2, 0, 0, 0, 1);
        add(0, 1, 32'h80,       1, 1, 1,  1, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'h0,        0, 0, 0,  1, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].av, vecs[i].pc, vecs[i].ap, vecs[i].rv, vecs[i].rt);
            check("alloc_ready",   i, 32'(alloc_ready),   32'(vecs[i].e_rdy));
            check("spec_hist",     i, 32'(spec_hist),     32'(vecs[i].e_sh));
            check("upd_valid",     i, 32'(upd_valid),     32'(vecs[i].e_uv));
            check("flush",         i, 32'(flush),         32'(vecs[i].e_fl));
            check("branch_cnt",    i, branch_cnt,         vecs[i].e_bc);
            check("correct_cnt",   i, correct_cnt,        vecs[i].e_cc);
            check("err_underflow", i, 32'(err_underflow), 32'(vecs[i].e_uf));
            check("count",         i, 32'(dbg_count),     32'(vecs[i].e_cnt));
            check("state",         i, 32'(dbg_state),     32'(vecs[i].e_st));
            if (vecs[i].e_uv) begin
                check("upd_index", i, 32'(upd_index), 32'(vecs[i].e_ui));
                check("upd_taken", i, 32'(upd_taken), 32'(vecs[i].e_ut));
            end
        end

        // Alternating allocate/resolve stream with correct predictions, starting from reset state.
        sh_m = 8'h00;
        bc_m = 32'd0;
        for (int i = 0; i < 6; i++) begin
            pc   = 32'h0000_1000 + 32'(i) * 32'h44;
            pred = (i % 2) == 1;
            snap = sh_m;
            drive(1'b1, 1'b1, pc, pred, 1'b0, 1'b0);
            sh_m = {sh_m[6:0], pred};
            check("seq spec_hist", 100 + i, 32'(spec_hist), 32'(sh_m));
            check("seq count",     100 + i, 32'(dbg_count), 32'd1);
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, pred);
            bc_m = bc_m + 32'd1;
            check("seq upd_valid", 100 + i, 32'(upd_valid), 32'd1);
            check("seq upd_index", 100 + i, 32'(upd_index), 32'(exp_index(pc, snap)));
            check("seq upd_taken", 100 + i, 32'(upd_taken), 32'(pred));
            check("seq flush",     100 + i, 32'(flush),     32'd0);
            check("seq branch",    100 + i, branch_cnt,     bc_m);
            check("seq correct",   100 + i, correct_cnt,    bc_m);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("seq idle upd_valid", 200, 32'(upd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
